// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: Y86 icodes, modes, fetch FSM states.
package ifu_pkg;

  localparam logic MODE_MIPS = 1'b0;
  localparam logic MODE_Y86  = 1'b1;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVL = 4'h2;
  localparam logic [3:0] ICODE_IRMOVL = 4'h3;
  localparam logic [3:0] ICODE_RMMOVL = 4'h4;
  localparam logic [3:0] ICODE_MRMOVL = 4'h5;
  localparam logic [3:0] ICODE_OPL    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHL  = 4'hA;
  localparam logic [3:0] ICODE_POPL   = 4'hB;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT         = 2'd1,
    WAIT_DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/y86_len_decode.sv
// Combinational Y86 instruction length decode from the icode nibble; flags undefined icodes.
module y86_len_decode
  import ifu_pkg::*;
(
  input  logic [3:0] icode,
  output logic [2:0] len,
  output logic       badop
);

  // icode -> byte length; undefined icodes are one byte and flagged
  always_comb begin
    len   = 3'd1;
    badop = 1'b0;
    case (icode)
      ICODE_HALT, ICODE_NOP, ICODE_RET:                  len = 3'd1;
      ICODE_RRMOVL, ICODE_OPL, ICODE_PUSHL, ICODE_POPL:  len = 3'd2;
      ICODE_JXX, ICODE_CALL:                             len = 3'd5;
      ICODE_IRMOVL, ICODE_RMMOVL, ICODE_MRMOVL:          len = 3'd6;
      default: begin
        len   = 3'd1;
        badop = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: word fetches into a byte queue, 48-bit instruction window.
// Optional macro IFU_BADOP_TRAP_EN traps undefined Y86 icodes at the queue head.
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int          BUF_BYTES  = 12,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic        RESET_MODE = 1'b0
) (
  input  logic        clk,
  input  logic        clrn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        redirect_mode,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [47:0] inst,
  output logic [2:0]  inst_len,
  output logic        mode,
  output logic [31:0] next_inst_pc,
  output logic        fetch_err
);

  localparam int CW = $clog2(BUF_BYTES + 1);
  localparam int QW = BUF_BYTES * 8;

  fetch_state_e  state_r, state_nxt_s;
  logic [QW-1:0] q_r, q_nxt_s, app_s;
  logic [CW-1:0] count_r, count_nxt_s, cnt_pop_s;
  logic [31:0]   pc_r, pc_nxt_s, fetch_addr_r, fetch_addr_nxt_s;
  logic [31:0]   req_addr_r, req_addr_nxt_s, word_s;
  logic [1:0]    skip_r, skip_nxt_s;
  logic          mode_r, mode_nxt_s, req_r, req_nxt_s, err_r, err_nxt_s;
  logic [2:0]    y86_len_s, len_s, app_bytes_s;
  logic          badop_s, pop_s, take_s, trap_s;

  y86_len_decode u_len_decode (
    .icode (q_r[7:4]),
    .len   (y86_len_s),
    .badop (badop_s)
  );

`ifdef IFU_BADOP_TRAP_EN
  assign trap_s = (mode_r == MODE_Y86) && (count_r != '0) && badop_s;
`else
  logic unused_badop_s;
  assign unused_badop_s = badop_s;
  assign trap_s         = 1'b0;
`endif

  // Queue bytes beyond count are kept zero, so the window needs no masking
  assign len_s        = (mode_r == MODE_Y86) ? y86_len_s : 3'd4;
  assign inst         = q_r[47:0];
  assign inst_len     = len_s;
  assign mode         = mode_r;
  assign next_inst_pc = pc_r + {29'd0, len_s};
  assign inst_valid   = (count_r != '0) && (count_r >= CW'(len_s)) && !err_r;
  assign fetch_err    = err_r;
  assign imem_req     = req_r;
  assign imem_addr    = req_addr_r;

  assign pop_s       = inst_valid && inst_ready;
  assign take_s      = (state_r == WAIT) && imem_ack && !redirect;
  assign cnt_pop_s   = count_r - (pop_s ? CW'(len_s) : CW'(0));
  assign word_s      = imem_rdata >> {skip_r, 3'b000};
  assign app_bytes_s = 3'd4 - {1'b0, skip_r};
  assign app_s       = {{(QW-32){1'b0}}, word_s} << {cnt_pop_s, 3'b000};

  // Queue, pc, mode and fetch pointer update; redirect overrides pop and ack
  always_comb begin
    q_nxt_s          = q_r;
    count_nxt_s      = count_r;
    pc_nxt_s         = pc_r;
    mode_nxt_s       = mode_r;
    fetch_addr_nxt_s = fetch_addr_r;
    skip_nxt_s       = skip_r;
    err_nxt_s        = err_r;
    if (redirect) begin
      q_nxt_s          = '0;
      count_nxt_s      = '0;
      mode_nxt_s       = redirect_mode;
      pc_nxt_s         = (redirect_mode == MODE_Y86) ? redirect_pc : {redirect_pc[31:2], 2'b00};
      fetch_addr_nxt_s = {redirect_pc[31:2], 2'b00};
      skip_nxt_s       = (redirect_mode == MODE_Y86) ? redirect_pc[1:0] : 2'b00;
      err_nxt_s        = 1'b0;
    end else begin
      q_nxt_s     = q_r >> (pop_s ? {len_s, 3'b000} : 6'd0);
      count_nxt_s = cnt_pop_s;
      pc_nxt_s    = pop_s ? next_inst_pc : pc_r;
      err_nxt_s   = err_r | trap_s;
      if (take_s) begin
        q_nxt_s          = q_nxt_s | app_s;
        count_nxt_s      = cnt_pop_s + CW'(app_bytes_s);
        fetch_addr_nxt_s = fetch_addr_r + 32'd4;
        skip_nxt_s       = 2'b00;
      end else begin
        fetch_addr_nxt_s = fetch_addr_r;
      end
    end
  end

  // Fetch FSM: one request outstanding; a redirect mid-request discards its data
  always_comb begin
    state_nxt_s    = state_r;
    req_addr_nxt_s = req_addr_r;
    case (state_r)
      IDLE: begin
        if (!redirect && (int'(cnt_pop_s) + 4 <= BUF_BYTES)) begin
          state_nxt_s    = WAIT;
          req_addr_nxt_s = fetch_addr_r;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          state_nxt_s = IDLE;
        end else if (redirect) begin
          state_nxt_s = WAIT_DISCARD;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      WAIT_DISCARD: begin
        if (imem_ack) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_DISCARD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
    req_nxt_s = (state_nxt_s != IDLE);
  end

  // State registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r      <= IDLE;
      q_r          <= '0;
      count_r      <= '0;
      pc_r         <= RESET_PC;
      mode_r       <= RESET_MODE;
      fetch_addr_r <= {RESET_PC[31:2], 2'b00};
      req_addr_r   <= {RESET_PC[31:2], 2'b00};
      skip_r       <= RESET_PC[1:0];
      req_r        <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      q_r          <= q_nxt_s;
      count_r      <= count_nxt_s;
      pc_r         <= pc_nxt_s;
      mode_r       <= mode_nxt_s;
      fetch_addr_r <= fetch_addr_nxt_s;
      req_addr_r   <= req_addr_nxt_s;
      skip_r       <= skip_nxt_s;
      req_r        <= req_nxt_s;
      err_r        <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit with a word memory responder.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        imem_req, imem_ack, redirect, redirect_mode, inst_valid, inst_ready;
  logic        mode, fetch_err;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, next_inst_pc;
  logic [47:0] inst;
  logic [2:0]  inst_len;

  logic [31:0] wmem [0:1023];
  int          lat = 0;
  int          lat_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .BUF_BYTES  (12),
    .RESET_PC   (32'h0000_0000),
    .RESET_MODE (1'b0)
  ) dut (
    .clk           (clk),
    .clrn          (clrn),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .redirect_mode (redirect_mode),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_len      (inst_len),
    .mode          (mode),
    .next_inst_pc  (next_inst_pc),
    .fetch_err     (fetch_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic redirect_to(input logic [31:0] pc, input logic m);
    redirect      = 1'b1;
    redirect_pc   = pc;
    redirect_mode = m;
    @(negedge clk);
    redirect = 1'b0;
  endtask

  task automatic expect_inst(input string tag, input logic [47:0] e_inst,
                             input logic [2:0] e_len, input logic [31:0] e_npc);
    int          n;
    logic [47:0] mask;
    n = 0;
    while (!inst_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    mask = 48'hFFFF_FFFF_FFFF >> (8 * (6 - int'(e_len)));
    check_eq({tag, " valid"}, 64'(inst_valid), 64'd1);
    check_eq({tag, " inst"}, 64'(inst & mask), 64'(e_inst));
    check_eq({tag, " len"}, 64'(inst_len), 64'(e_len));
    check_eq({tag, " npc"}, 64'(next_inst_pc), 64'(e_npc));
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
  endtask

  // Memory responder: ack 'lat' cycles after a request is first seen
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (imem_ack) begin
        imem_ack = 1'b0;
      end else if (imem_req) begin
        if (lat_cnt >= lat) begin
          imem_rdata = wmem[imem_addr[11:2]];
          imem_ack   = 1'b1;
          lat_cnt    = 0;
        end else begin
          lat_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    redirect      = 1'b0;
    redirect_pc   = 32'h0;
    redirect_mode = 1'b0;
    inst_ready    = 1'b0;
    for (int i = 0; i < 1024; i++) wmem[i] = 32'h0;
    wmem[0]     = 32'h2008_0005;
    wmem[1]     = 32'h8C09_0004;
    wmem[2]     = 32'h0109_5020;
    wmem[3]     = 32'hAC0A_0008;
    wmem[10'h40] = 32'hF330_BBAA;
    wmem[10'h41] = 32'h1234_5678;
    wmem[10'h42] = 32'h9010_1260;
    wmem[10'h80] = 32'h1111_2222;
    for (int i = 0; i < 6; i++) wmem[10'hC0 + i] = 32'hA000_0000 + 32'(i);
    wmem[10'h100] = 32'hDEAD_0400;
    wmem[10'h140] = 32'h0500_AAAA;
    wmem[10'h141] = 32'h0500_BBBB;
    wmem[10'h180] = 32'h0000_10C0;

    repeat (2) @(negedge clk);
    check_eq("rst req", 64'(imem_req), 64'd0);
    check_eq("rst valid", 64'(inst_valid), 64'd0);
    check_eq("rst err", 64'(fetch_err), 64'd0);
    check_eq("rst mode", 64'(mode), 64'd0);
    check_eq("rst npc", 64'(next_inst_pc), 64'h4);
    clrn = 1'b1;
    #1;
    check_eq("first req delay", 64'(imem_req), 64'd0);
    @(negedge clk);
    check_eq("first req", 64'(imem_req), 64'd1);
    check_eq("first addr", 64'(imem_addr), 64'h0);

    // MIPS words in order
    expect_inst("t1 w0", 48'h2008_0005, 3'd4, 32'h4);
    expect_inst("t1 w1", 48'h8C09_0004, 3'd4, 32'h8);
    expect_inst("t1 w2", 48'h0109_5020, 3'd4, 32'hC);
    expect_inst("t1 w3", 48'hAC0A_0008, 3'd4, 32'h10);

    // Unaligned Y86 redirect
    redirect_to(32'h0000_0102, 1'b1);
    check_eq("t2 mode", 64'(mode), 64'd1);
    expect_inst("t2 irmovl", 48'h1234_5678_F330, 3'd6, 32'h108);
    expect_inst("t2 opl", 48'h1260, 3'd2, 32'h10A);
    expect_inst("t2 nop", 48'h10, 3'd1, 32'h10B);
    expect_inst("t2 ret", 48'h90, 3'd1, 32'h10C);

    // Pop and redirect in the same cycle
    n = 0;
    while (!inst_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    inst_ready = 1'b1;
    redirect_to(32'h0000_0203, 1'b0);
    inst_ready = 1'b0;
    check_eq("t5 valid", 64'(inst_valid), 64'd0);
    check_eq("t5 npc", 64'(next_inst_pc), 64'h204);
    check_eq("t5 mode", 64'(mode), 64'd0);
    check_eq("t5 inst", 64'(inst), 64'd0);
    expect_inst("t5 first", 48'h1111_2222, 3'd4, 32'h204);

    // Back-pressure fills the queue, then drains in order
    redirect_to(32'h0000_0300, 1'b0);
    repeat (20) @(negedge clk);
    check_eq("t3 full req", 64'(imem_req), 64'd0);
    check_eq("t3 full valid", 64'(inst_valid), 64'd1);
    check_eq("t3 full window", 64'(inst), 64'h0001_A000_0000);
    for (int i = 0; i < 6; i++)
      expect_inst("t3 drain", 48'(32'hA000_0000 + 32'(i)), 3'd4, 32'h304 + 32'(4 * i));

    // Redirect while a request is outstanding
    lat = 3;
    redirect_to(32'h0000_0400, 1'b0);
    n = 0;
    while (!(imem_req && imem_addr == 32'h400) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("t4 req seen", 64'(imem_req && imem_addr == 32'h400), 64'd1);
    redirect_to(32'h0000_0500, 1'b0);
    check_eq("t4 req held", 64'(imem_req), 64'd1);
    check_eq("t4 addr held", 64'(imem_addr), 64'h400);
    expect_inst("t4 first", 48'h0500_AAAA, 3'd4, 32'h504);
    expect_inst("t4 second", 48'h0500_BBBB, 3'd4, 32'h508);
    lat = 0;

    // Undefined Y86 icode at the head
    redirect_to(32'h0000_0600, 1'b1);
`ifdef IFU_BADOP_TRAP_EN
    n = 0;
    while (!fetch_err && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6 err set", 64'(fetch_err), 64'd1);
    check_eq("t6 valid low", 64'(inst_valid), 64'd0);
    repeat (5) @(negedge clk);
    check_eq("t6 err held", 64'(fetch_err), 64'd1);
    check_eq("t6 valid held", 64'(inst_valid), 64'd0);
    redirect_to(32'h0000_0108, 1'b1);
    check_eq("t6 err clear", 64'(fetch_err), 64'd0);
    expect_inst("t6 recover", 48'h1260, 3'd2, 32'h10A);
`else
    expect_inst("t6 badop", 48'hC0, 3'd1, 32'h601);
    check_eq("t6 err", 64'(fetch_err), 64'd0);
    expect_inst("t6 next", 48'h10, 3'd1, 32'h602);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
